// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response and data_memory signals for mem_access_unit.
// slave is the unit itself; master is the CPU plus memory environment driving it.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wrt;
  logic [31:0] mem_dout;
  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_dout,
    output ready, done, err, rdata, mem_addr, mem_din, mem_wrt
  );
  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_dout,
    input  ready, done, err, rdata, mem_addr, mem_din, mem_wrt
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store unit over a word-wide memory.
// Sub-word stores read the word, merge the lane, then write it back.
module mem_access_unit (
  input logic            clk,
  input logic            rst_n,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;
  state_t      state, state_nx;
  logic        l_we, l_sext, err_q, bad, word_st;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata, word_q, rdata_q, mask, lane, ext;
  logic [4:0]  sh;
  always_comb begin
    bad      = bus.size == 2'b11 || (bus.size == 2'b01 && bus.addr[0]) ||
               (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    word_st  = l_we && l_size == 2'b10;
    sh       = {l_addr[1:0], 3'b000};
    mask     = (l_size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    // word requests are aligned, so sh is zero and lane is the whole word
    lane     = bus.mem_dout >> sh;
    ext      = l_size == 2'b00 ? {{24{l_sext & lane[7]}}, lane[7:0]} :
               l_size == 2'b01 ? {{16{l_sext & lane[15]}}, lane[15:0]} : lane;
    state_nx = state == IDLE   ? (bus.req ? (bad ? DONE : ACCESS) : IDLE) :
               state == ACCESS ? (word_st || !l_we ? DONE : MERGE) :
               state == MERGE  ? DONE : IDLE;
    bus.ready    = state == IDLE;
    bus.done     = state == DONE;
    bus.err      = state == DONE && err_q;
    bus.mem_wrt  = (state == ACCESS && word_st) || state == MERGE;
    bus.mem_addr = state == IDLE ? {bus.addr[31:2], 2'b00} : {l_addr[31:2], 2'b00};
    bus.mem_din  = state == MERGE ? (word_q & ~mask) | ((l_wdata << sh) & mask) : l_wdata;
    bus.rdata    = rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      l_we    <= 1'b0;
      l_sext  <= 1'b0;
      l_size  <= 2'b00;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      err_q   <= 1'b0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.req) begin
        l_we    <= bus.we;
        l_sext  <= bus.sign_ext;
        l_size  <= bus.size;
        l_addr  <= bus.addr;
        l_wdata <= bus.wdata;
        err_q   <= bad;
      end
      if (state == ACCESS) begin
        word_q <= bus.mem_dout;
        if (!l_we) rdata_q <= ext;
      end
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port req, input, 1 bit: CPU access request, sampled only in IDLE.
REQ-004 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-006 SHALL have port sign_ext, input, 1 bit: loads only; 1 = sign-extend, 0 = zero-extend.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: store data, right-justified.
REQ-009 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1 bit: misalignment or illegal-size flag, valid with done.
REQ-012 SHALL have port rdata, output, 32 bits: extended load result, held until the next load completes.
REQ-013 SHALL have port mem_addr, output, 32 bits: word address to data_memory, {addr[31:2],2'b00}.
REQ-014 SHALL have port mem_din, output, 32 bits: write data to data_memory.
REQ-015 SHALL have port mem_wrt, output, 1 bit: write enable to data_memory, which writes on the rising clk edge.
REQ-016 SHALL have port mem_dout, input, 32 bits: data_memory read data, combinational from mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, MERGE, DONE; all outputs except rdata SHALL decode from state and latched request only.
REQ-018 IDLE SHALL behave as follows.
- On req=1 with a legal aligned request: latch we, size, sign_ext, addr, wdata; go to ACCESS.
- On req=1 with a misaligned or illegal request: latch err=1; go to DONE; never assert mem_wrt.
- On req=0: stay in IDLE.
REQ-019 Misalignment SHALL be halfword with addr[0]=1, word with addr[1:0]≠00, or size=11.
REQ-020 ACCESS SHALL behave by request type.
- Word store: assert mem_wrt=1 with mem_din=wdata; go to DONE.
- Load or sub-word store: capture mem_dout into an internal word register, mem_wrt=0.
- Load next state: DONE.
- Sub-word store next state: MERGE.
REQ-021 MERGE SHALL assert mem_wrt=1 with mem_din equal to the captured word with the selected lane replaced; go to DONE.
REQ-022 Lane selection SHALL be little-endian.
- Byte lane addr[1:0] maps to bits [8*addr[1:0]+7 : 8*addr[1:0]].
- Halfword addr[1]=0 maps to [15:0]; addr[1]=1 maps to [31:16].
REQ-023 Load extraction SHALL use the same lanes, then extend to 32 bits per sign_ext; word loads SHALL pass through unchanged; rdata SHALL update on the ACCESS→DONE edge.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; err SHALL be 1 only in DONE for a rejected request.
REQ-025 Latency from the accepting edge to the done cycle SHALL be:
- Rejected request: 1 cycle.
- Load or word store: 2 cycles.
- Sub-word store: 3 cycles.
REQ-026 mem_wrt SHALL be high at most one cycle per request, never in IDLE or DONE.
REQ-027 req SHALL be ignored while ready=0; back-to-back requests SHALL require req held or re-presented in IDLE.
REQ-028 mem_addr SHALL equal the latched word address in ACCESS and MERGE, and the live {addr[31:2],2'b00} in IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately force the following values, regardless of clk and including mid-MERGE:
- state = IDLE.
- mem_wrt = 0, done = 0, err = 0.
- rdata = 0, internal registers = 0.
- ready = 1.
REQ-030 The first request SHALL be accepted on the first rising edge with rst_n=1 and req=1.

Verification
REQ-031 Word store then load.
- Stimulus: store word 0x12481248 to addr 0x8, then load word from 0x8.
- Response: mem_wrt high 1 cycle at mem_addr 0x8; rdata=0x12481248 2 cycles after the load is accepted.
REQ-032 Byte store merge.
- Stimulus: memory word 0x8 = 0x24812481; store byte wdata=0xFF at addr 0xA.
- Response: mem_din=0x24FF2481 in MERGE; done 3 cycles after accept.
REQ-033 Sub-word load extension.
- Stimulus: word 0x8 = 0x81244812; load half at 0xA with sign_ext=1, then with sign_ext=0; load byte at 0x8 with sign_ext=1.
- Response: rdata=0xFFFF8124, then 0x00008124, then 0x00000012.
REQ-034 Misaligned request.
- Stimulus: word store at 0x6, or halfword load at 0x5.
- Response: done and err high the next cycle; mem_wrt never asserted; memory unchanged.
REQ-035 Reset mid-operation.
- Stimulus: rst_n driven low during MERGE of a byte store.
- Response: mem_wrt drops without waiting for clk; memory word unchanged; ready=1; rdata=0.
REQ-036 Busy and back-to-back.
- Stimulus: req held high continuously with alternating loads and stores.
- Response: requests ignored while ready=0; each access completes in order with correct done spacing of 3 or 4 cycles.
